// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C init sequencer: op codes, table entry layout and FSM states.
package i2c_seq_pkg;

  localparam int ENTRY_W  = 26;
  localparam int OP_LSB   = 24;
  localparam int DEV_LSB  = 16;
  localparam int ADDR_LSB = 8;
  localparam int DATA_LSB = 0;

  // Op 3 has no name on purpose; the decoder treats it like OP_END.
  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_DELAY = 2'd1,
    OP_END   = 2'd2
  } op_e;

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ACC,
    S_WAIT_CMP,
    S_DELAY,
    S_FIN
  } state_e;

endpackage

// File: rtl/i2c_seq_rom.sv
// Command table for the I2C init sequencer: synchronous read, one cycle of latency.
// The table image is supplied at build time through INIT_IMAGE. Entry 0 sits in the LSBs.
module i2c_seq_rom
  import i2c_seq_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int AW        = $clog2(N_ENTRIES),
  parameter logic [N_ENTRIES*ENTRY_W-1:0] INIT_IMAGE = '0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  output entry_t        rdata_o
);

  entry_t mem [N_ENTRIES];
  entry_t rdata_q;

  for (genvar g = 0; g < N_ENTRIES; g++) begin : g_mem
    assign mem[g] = INIT_IMAGE[g*ENTRY_W +: ENTRY_W];
  end

  always_ff @(posedge clk) begin
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/i2c_init_seq.sv
// Table-driven I2C initialisation sequencer: walks a command ROM issuing writes and delays.
// Optional single-step support is enabled by defining I2C_SEQ_STEP_EN.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | table read in flight for idx, then decode op
// ISSUE     | latch command fields, raise i2c_valid
// WAIT_ACC  | valid high, waiting for master to go busy (bounded by TIMEOUT)
// WAIT_CMP  | master busy, waiting for it to return idle
// DELAY     | counting {addr,data} ticks of TICK_DIV cycles
// FIN       | set done if no error, return to IDLE
module i2c_init_seq
  import i2c_seq_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int TICK_DIV  = 1000,
  parameter int TIMEOUT   = 65535,
  parameter logic [N_ENTRIES*ENTRY_W-1:0] INIT_IMAGE = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
`ifdef I2C_SEQ_STEP_EN
  input  logic                         step_mode,
  input  logic                         step,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(N_ENTRIES)-1:0] idx,
  output logic                         i2c_valid,
  input  logic                         i2c_ready,
  output logic [7:0]                   i2c_device,
  output logic [7:0]                   i2c_addr,
  output logic [7:0]                   i2c_data
);

  localparam int IDX_W  = $clog2(N_ENTRIES);
  localparam int CNT_W  = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_ENTRIES - 1);
  localparam logic [CNT_W-1:0]  TO_LOAD   = CNT_W'(TIMEOUT - 1);
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(TICK_DIV - 1);

  // Assert asynchronously, release on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  logic step_hold;
`ifdef I2C_SEQ_STEP_EN
  assign step_hold = step_mode & ~step;
`else
  assign step_hold = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d, err_q, err_d, abort_q, abort_d, valid_q, valid_d;
  logic [7:0]        dev_q, dev_d, addr_q, addr_d, data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              abort_pend, advance;
  logic [1:0]        op_bits;
  entry_t            ent;

  // Addressing with idx_d lets the read overlap the transition into FETCH.
  i2c_seq_rom #(.N_ENTRIES(N_ENTRIES), .AW(IDX_W), .INIT_IMAGE(INIT_IMAGE)) u_rom (
    .clk     (clk),
    .addr_i  (idx_d),
    .rdata_o (ent)
  );

  assign op_bits = ent[OP_LSB +: 2];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    done_d     = done_q;
    err_d      = err_q;
    abort_d    = abort_q;
    valid_d    = valid_q;
    dev_d      = dev_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    tick_d     = tick_q;
    advance    = 1'b0;
    abort_pend = abort_q | abort;
    if (state_q != S_IDLE && abort) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort_pend) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (!step_hold) begin
          case (op_bits)
            OP_WRITE: state_d = S_ISSUE;
            OP_DELAY: begin
              cnt_d   = CNT_W'({ent[ADDR_LSB +: 8], ent[DATA_LSB +: 8]});
              tick_d  = TICK_LOAD;
              state_d = S_DELAY;
            end
            default:  state_d = S_FIN;
          endcase
        end
      end
      S_ISSUE: begin
        dev_d   = ent[DEV_LSB +: 8];
        addr_d  = ent[ADDR_LSB +: 8];
        data_d  = ent[DATA_LSB +: 8];
        valid_d = 1'b1;
        cnt_d   = TO_LOAD;
        state_d = S_WAIT_ACC;
      end
      S_WAIT_ACC: begin
        if (!i2c_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT_CMP;
        end else if (cnt_q == '0) begin
          valid_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_CMP: advance = i2c_ready;
      S_DELAY: begin
        if (abort_pend) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (cnt_q == '0) begin
          advance = 1'b1;
        end else if (tick_q == '0) begin
          tick_d = TICK_LOAD;
          cnt_d  = cnt_q - 1'b1;
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      S_FIN: begin
        done_d  = ~err_q;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Running off the end of the table is an implicit END.
    if (advance) begin
      if (idx_q == IDX_LAST) begin
        state_d = S_FIN;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      valid_q <= 1'b0;
      dev_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      valid_q <= valid_d;
      dev_q   <= dev_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign idx        = idx_q;
  assign i2c_valid  = valid_q;
  assign i2c_device = dev_q;
  assign i2c_addr   = addr_q;
  assign i2c_data   = data_q;

endmodule

// File: doc/i2c_init_seq.md
I2C_INIT_SEQ -- requirements
Module: i2c_init_seq

Interface
REQ-001 The block SHALL have parameter N_ENTRIES, default 16, meaning the command table depth (power of 2, at most 256).
REQ-002 The block SHALL have parameter TICK_DIV, default 1000, meaning the clk cycles per delay tick.
REQ-003 The block SHALL have parameter TIMEOUT, default 65535, meaning the clk cycles allowed for the master to accept a command.
REQ-004 Port clk, input, 1 bit: the single clock. All logic SHALL be on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: one-cycle pulse that runs the table from entry 0.
REQ-007 Port abort, input, 1 bit: one-cycle pulse that stops the sequence at the next safe point.
REQ-008 Port busy, output, 1 bit: a sequence is in progress.
REQ-009 Port done, output, 1 bit: sticky flag set when the last run completed normally.
REQ-010 Port err, output, 1 bit: sticky flag set on timeout or abort.
REQ-011 Port idx, output, $clog2(N_ENTRIES) bits: index of the current or last entry.
REQ-012 Port i2c_valid, output, 1 bit: command request to the I2C master.
REQ-013 Port i2c_ready, input, 1 bit: the master is idle.
REQ-014 Ports i2c_device, i2c_addr and i2c_data SHALL be outputs of 8 bits each, giving the command fields to the master.

Function
REQ-015 Each table entry SHALL be 26 bits: {op[1:0], device[7:0], addr[7:0], data[7:0]}.
REQ-016 Op codes SHALL be WRITE=0, DELAY=1 and END=2; op 3 SHALL be treated as END.
REQ-017 States SHALL be IDLE, FETCH, ISSUE, WAIT_ACC, WAIT_CMP, DELAY and FIN.
REQ-018 IDLE: a start pulse SHALL set idx=0, clear done and err, and go to FETCH; start SHALL be ignored in all other states.
REQ-019 FETCH: the block SHALL wait one cycle for the table read, then decode the op.
REQ-020 FETCH decode: WRITE SHALL go to ISSUE, DELAY SHALL go to DELAY, END SHALL go to FIN.
REQ-021 ISSUE SHALL register the device, addr and data fields, assert i2c_valid, and go to WAIT_ACC.
REQ-022 In ISSUE, the output fields SHALL be stable for the whole time i2c_valid is high.
REQ-023 WAIT_ACC: on the first cycle i2c_ready is sampled low, i2c_valid SHALL drop on the next edge and the state SHALL go to WAIT_CMP.
REQ-024 WAIT_ACC: after TIMEOUT cycles with i2c_ready still high, i2c_valid SHALL drop, err SHALL be set, and the state SHALL go to FIN.
REQ-025 WAIT_CMP: when i2c_ready is sampled high, the block SHALL advance to the next entry.
REQ-026 DELAY: the block SHALL wait {addr,data} ticks of TICK_DIV cycles each, then advance.
REQ-027 A DELAY count of 0 SHALL advance after 1 cycle.
REQ-028 Advance: when idx == N_ENTRIES-1 the state SHALL go to FIN (implicit END, no wrap); otherwise idx SHALL increment and the state SHALL go to FETCH.
REQ-029 Abort SHALL be latched in any busy state and acted on only in FETCH or DELAY; it SHALL never act during WAIT_ACC or WAIT_CMP.
REQ-030 Acting on abort SHALL set err and go to FIN.
REQ-031 FIN SHALL set done only if err is clear, then go to IDLE after 1 cycle.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 A start and an abort in the same cycle in IDLE SHALL start the run and discard the abort.

Reset
REQ-034 While reset_n is low, the state SHALL be IDLE, and idx, busy, done, err, i2c_valid and the field outputs SHALL all be 0.
REQ-035 Reset SHALL take effect asynchronously, including mid-transfer; i2c_valid SHALL drop without waiting for a clock edge.
REQ-036 Reset release SHALL be synchronized to clk.

Configuration
REQ-037 With macro I2C_SEQ_STEP_EN defined, the block SHALL have an extra input step_mode and an extra input step (pulse).
REQ-038 With I2C_SEQ_STEP_EN defined and step_mode=1, FETCH SHALL hold until a step pulse before decoding each entry.
REQ-039 Without I2C_SEQ_STEP_EN, the step_mode and step ports SHALL be absent and FETCH SHALL never hold.

Structure
REQ-040 A shared package i2c_seq_pkg SHALL hold the op-code enum, the 26-bit entry typedef, the state enum and the field-offset constants.
REQ-041 The command table SHALL be the sub-module i2c_seq_rom: a synchronous read with 1-cycle latency, contents from an init file.

Verification
REQ-042 The bench SHALL drive the block against an i2c_master model with ready dropping 25 cycles after valid.
REQ-043 Table {WRITE 0x42/0x10/0xA5, END}, start -> one transfer, device=0x42, addr=0x10, data=0xA5; then done=1, err=0, idx=1.
REQ-044 i2c_ready held high, TIMEOUT=100 -> i2c_valid drops after 100 cycles; err=1, done=0.
REQ-045 Table {DELAY 3, END}, TICK_DIV=10 -> busy for 30 to 34 cycles; no i2c_valid pulse.
REQ-046 Abort during WAIT_CMP of entry 0 in a 3-WRITE table -> entry 0 completes; err=1 at next FETCH; entries 1 and 2 not issued.
REQ-047 reset_n low mid-WAIT_ACC -> i2c_valid=0 immediately; after release the block is IDLE and start is accepted.
REQ-048 N_ENTRIES=4 with no END entry -> exactly 4 transfers; done=1; idx=3.
